// File: rtl/calc_pkg.sv
// calc_pkg: opcode encodings, instruction field widths and FSM states for calc_core.
package calc_pkg;
  localparam int OPC_W = 4;
  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDX  = 4'h1;
  localparam logic [OPC_W-1:0] OP_LDY  = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h4;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h5;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h6;
  localparam logic [OPC_W-1:0] OP_NOTY = 4'h7;
  localparam logic [OPC_W-1:0] OP_MOVZ = 4'h8;
  localparam logic [OPC_W-1:0] OP_CLR  = 4'h9;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'hA;
  localparam logic [OPC_W-1:0] OP_JZ   = 4'hB;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_e;
endpackage

// File: rtl/calc_alu.sv
// calc_alu: combinational ALU; result plus carry/zero and which flags the opcode may update.
module calc_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [OPC_W-1:0] i_op,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic [WIDTH-1:0] o_res,
  output logic             o_carry,
  output logic             o_zero,
  output logic             o_upd_c,
  output logic             o_upd_z
);
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_dif;
  assign w_sum = {1'b0, i_y} + {1'b0, i_x};
  // top bit of the widened difference is the borrow
  assign w_dif = {1'b0, i_y} - {1'b0, i_x};
  assign o_res = i_op == OP_ADD  ? w_sum[WIDTH-1:0] :
                 i_op == OP_SUB  ? w_dif[WIDTH-1:0] :
                 i_op == OP_AND  ? i_y & i_x :
                 i_op == OP_OR   ? i_y | i_x :
                 i_op == OP_NOTY ? ~i_y : '0;
  assign o_carry = i_op == OP_SUB ? w_dif[WIDTH] : w_sum[WIDTH];
  assign o_zero  = o_res == '0;
  assign o_upd_c = i_op == OP_ADD || i_op == OP_SUB;
  assign o_upd_z = i_op >= OP_ADD && i_op <= OP_NOTY;
endmodule

// File: rtl/calc_core.sv
// calc_core: programmable accumulator calculator with program memory, fetch/exec FSM,
// X/Y/Z registers, carry/zero flags, jumps, HALT and sticky illegal-opcode detection.
module calc_core
  import calc_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   prog_we,
  input  logic [ADDR_W-1:0]      prog_addr,
  input  logic [OPC_W+WIDTH-1:0] prog_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   illegal,
  output logic                   carry,
  output logic                   zero,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [WIDTH-1:0]       out_x,
  output logic [WIDTH-1:0]       out_y,
  output logic [WIDTH-1:0]       out_z,
  output logic [WIDTH-1:0]       out_alu
);
  localparam int IW = OPC_W + WIDTH;
  logic [IW-1:0]     r_mem [2**ADDR_W];
  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [IW-1:0]     r_ir;
  logic [WIDTH-1:0]  r_x, r_y, r_z;
  logic              r_done, r_ill, r_c, r_zf;
  logic [OPC_W-1:0]  w_op;
  logic [WIDTH-1:0]  w_imm, w_res;
  logic [ADDR_W-1:0] w_tgt;
  logic              w_carry, w_zero, w_upd_c, w_upd_z, w_jump;
  assign w_op   = r_ir[IW-1:WIDTH];
  assign w_imm  = r_ir[WIDTH-1:0];
  assign w_tgt  = ADDR_W'(w_imm);
  assign w_jump = w_op == OP_JMP || (w_op == OP_JZ && r_zf);
  calc_alu #(.WIDTH(WIDTH)) u_alu (
    .i_op   (w_op),
    .i_x    (r_x),
    .i_y    (r_y),
    .o_res  (w_res),
    .o_carry(w_carry),
    .o_zero (w_zero),
    .o_upd_c(w_upd_c),
    .o_upd_z(w_upd_z)
  );
  // program memory has no reset so a stored program survives rst_n
  always_ff @(posedge clk)
    if (prog_we && r_state == S_IDLE) r_mem[prog_addr] <= prog_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_done  <= 1'b0;
      r_ill   <= 1'b0;
      r_c     <= 1'b0;
      r_zf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_FETCH;
          r_pc    <= '0;
          r_ill   <= 1'b0;
        end
        S_FETCH: begin
          r_ir    <= r_mem[r_pc];
          r_state <= S_EXEC;
        end
        default: begin
          r_pc    <= w_jump ? w_tgt : r_pc + 1'b1;
          r_state <= w_op == OP_HALT ? S_IDLE : S_FETCH;
          r_done  <= w_op == OP_HALT;
          r_ill   <= r_ill | (w_op > OP_JZ && w_op < OP_HALT);
          r_x     <= w_op == OP_LDX ? w_imm : w_op == OP_CLR ? '0 : r_x;
          r_y     <= w_op == OP_LDY ? w_imm : w_op == OP_CLR ? '0 : w_upd_z ? w_res : r_y;
          r_z     <= w_op == OP_MOVZ ? r_y : w_op == OP_CLR ? '0 : r_z;
          if (w_upd_c) r_c <= w_carry;
          if (w_upd_z) r_zf <= w_zero;
        end
      endcase
    end
  assign busy    = r_state != S_IDLE;
  assign done    = r_done;
  assign illegal = r_ill;
  assign carry   = r_c;
  assign zero    = r_zf;
  assign out_pc  = r_pc;
  assign out_x   = r_x;
  assign out_y   = r_y;
  assign out_z   = r_z;
  assign out_alu = w_res;
endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: directed programs with a scoreboard of expected PC trail and end-of-run state.
module tb_calc_core;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_wdata = '0;
  logic       busy, done, illegal, carry, zero;
  logic [3:0] out_pc, out_x, out_y, out_z, out_alu;
  calc_core #(.WIDTH(4), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .busy(busy), .done(done),
    .illegal(illegal), .carry(carry), .zero(zero), .out_pc(out_pc),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_alu(out_alu)
  );
  always #5 clk = ~clk;
  typedef struct { string tag; int val; } exp_t;
  exp_t       q[$];
  int         q_pc[$];
  logic [7:0] pq[$];
  int         n_run = 0, n_fail = 0, last_cyc = 0;
  task automatic chk(input string tag, input int o, input int e);
    n_run++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask
  function automatic int obs(input string t);
    case (t)
      "x":    return int'(out_x);
      "y":    return int'(out_y);
      "z":    return int'(out_z);
      "c":    return int'(carry);
      "zf":   return int'(zero);
      "ill":  return int'(illegal);
      "pc":   return int'(out_pc);
      "alu":  return int'(out_alu);
      "busy": return int'(busy);
      "done": return int'(done);
      "cyc":  return last_cyc;
      default: return -1;
    endcase
  endfunction
  task automatic expect_v(input string t, input int v);
    exp_t e;
    e.tag = t;
    e.val = v;
    q.push_back(e);
  endtask
  task automatic check_all();
    while (q.size() > 0) begin
      exp_t e = q.pop_front();
      chk(e.tag, obs(e.tag), e.val);
    end
  endtask
  task automatic expect_state(input int x, input int y, input int z, input int c,
                              input int zf, input int ill, input int pc, input int cyc);
    expect_v("x", x); expect_v("y", y); expect_v("z", z); expect_v("c", c);
    expect_v("zf", zf); expect_v("ill", ill); expect_v("pc", pc); expect_v("cyc", cyc);
  endtask
  task automatic load_prog();
    for (int i = 0; i < pq.size(); i++) begin
      @(negedge clk);
      prog_we = 1'b1;
      prog_addr = 4'(i);
      prog_wdata = pq[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask
  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  // we_c >= 0 pokes start and a write to address 0 at that cycle, both of which must be ignored
  task automatic run(input int we_c);
    int  c = 0;
    bit  seen = 1'b0;
    kick();
    while (!seen && c < 200) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        chk("busy_after_start", int'(busy), 1);
        chk("illegal_cleared", int'(illegal), 0);
      end
      if (c % 2 == 1 && busy && q_pc.size() > 0) chk("pc_trail", int'(out_pc), q_pc.pop_front());
      if (done) begin
        seen = 1'b1;
        chk("busy_at_done", int'(busy), 0);
      end
      prog_we = c == we_c;
      start = c == we_c;
      prog_addr = '0;
      prog_wdata = 8'h11;
    end
    prog_we = 1'b0;
    start = 1'b0;
    last_cyc = c;
    chk("done_seen", int'(seen), 1);
    chk("pc_trail_left", q_pc.size(), 0);
    check_all();
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
  endtask
  initial begin
    #2;
    expect_v("busy", 0); expect_v("done", 0); expect_v("ill", 0); expect_v("c", 0);
    expect_v("zf", 0); expect_v("pc", 0); expect_v("x", 0); expect_v("y", 0);
    expect_v("z", 0); expect_v("alu", 0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    // LDX 3, LDY 5, ADD, MOVZ, HALT
    pq = '{8'h13, 8'h25, 8'h30, 8'h80, 8'hF0};
    load_prog();
    q_pc = '{0, 1, 2, 3, 4};
    expect_state(3, 8, 8, 0, 0, 0, 5, 11);
    run(-1);
    // LDX 9, LDY 9, ADD, HALT with an ignored write/start mid-run, then a clean rerun
    pq = '{8'h19, 8'h29, 8'h30, 8'hF0};
    load_prog();
    q_pc = '{0, 1, 2, 3};
    expect_state(9, 2, 8, 1, 0, 0, 4, 9);
    run(3);
    q_pc = '{0, 1, 2, 3};
    expect_state(9, 2, 8, 1, 0, 0, 4, 9);
    run(-1);
    // SUB countdown loop with JZ/JMP
    pq = '{8'h11, 8'h23, 8'h40, 8'hB5, 8'hA2, 8'hF0};
    load_prog();
    q_pc = '{0, 1, 2, 3, 4, 2, 3, 4, 2, 3, 5};
    expect_state(1, 0, 8, 0, 1, 0, 6, 23);
    run(-1);
    // reserved opcode D then HALT
    pq = '{8'hD0, 8'hF0};
    load_prog();
    q_pc = '{0, 1};
    expect_state(1, 0, 8, 0, 1, 1, 2, 5);
    run(-1);
    // logic ops and borrow
    pq = '{8'h15, 8'h2A, 8'h50, 8'h60, 8'h70, 8'h80, 8'h40, 8'h22, 8'h40, 8'hF0};
    load_prog();
    q_pc = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    expect_state(5, 13, 10, 1, 0, 0, 10, 21);
    expect_v("alu", 0);
    run(-1);
    // CLR leaves flags untouched
    pq = '{8'h90, 8'hF0};
    load_prog();
    q_pc = '{0, 1};
    expect_state(0, 0, 0, 1, 0, 0, 2, 5);
    run(-1);
    // asynchronous reset mid-loop, then rerun the stored program
    pq = '{8'h11, 8'h23, 8'h40, 8'hB5, 8'hA2, 8'hF0};
    load_prog();
    kick();
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    expect_v("busy", 0); expect_v("done", 0); expect_v("ill", 0); expect_v("c", 0);
    expect_v("zf", 0); expect_v("pc", 0); expect_v("x", 0); expect_v("y", 0);
    expect_v("z", 0); expect_v("alu", 0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    q_pc = '{0, 1, 2, 3, 4, 2, 3, 4, 2, 3, 5};
    expect_state(1, 0, 0, 0, 1, 0, 6, 23);
    run(-1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
